// File: rtl/serv_rf_dbg_pkg.sv
// Shared definitions for the SERV register-file debug arbiter.
//   dbg_state_e : arbiter state encoding (idle, write beats, read beats, done)
//   REG_X0      : index of the hard-wired zero register
//   beats()     : RAM beats per 32-bit register for a given RAM width
//   reg_limit() : first illegal register index (GPRs followed by CSRs)
package serv_rf_dbg_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWr,
    StRd,
    StDone
  } dbg_state_e;

  localparam logic [5:0] REG_X0 = 6'd0;

  function automatic int unsigned beats(input int unsigned w);
    return 32 / w;
  endfunction

  function automatic int unsigned reg_limit(input int unsigned n_csr);
    return 32 + n_csr;
  endfunction

endpackage

// File: rtl/serv_rf_dbg_arb.sv
// Register-file RAM arbiter between the SERV RAM interface adapter and the RAM.
// The core owns the RAM port pair whenever no debug transfer is running; a
// 32-bit debug/loader port reads or writes whole registers by sequencing
// 32/width beats, LSB first, at address reg*beats + k.
//
// Ports:
//   clk, i_rst                 clock, asynchronous active-high reset
//   i_core_idle                core halted; debug transfers may start / continue
//   i_core_{waddr,wdata,wen}   core write port
//   i_core_raddr, o_core_rdata core read port (rdata always straight from RAM)
//   o_ram_{waddr,wdata,wen}    RAM write port
//   o_ram_raddr, i_ram_rdata   RAM read port (1-cycle registered read)
//   i_dbg_{req,we,reg,wdat}    debug request, direction, register, write data
//   o_dbg_rdat                 last completed read value
//   o_dbg_ack, o_dbg_err       single-cycle completion / reject-or-abort pulses
module serv_rf_dbg_arb
  import serv_rf_dbg_pkg::*;
#(
  parameter int unsigned width    = 2,
  parameter int unsigned csr_regs = 4,
  parameter int unsigned depth    = 32 * (32 + csr_regs) / width,
  parameter int unsigned aw       = $clog2(depth)
) (
  input  logic             clk,
  input  logic             i_rst,
  input  logic             i_core_idle,
  input  logic [aw-1:0]    i_core_waddr,
  input  logic [width-1:0] i_core_wdata,
  input  logic             i_core_wen,
  input  logic [aw-1:0]    i_core_raddr,
  output logic [width-1:0] o_core_rdata,
  output logic [aw-1:0]    o_ram_waddr,
  output logic [width-1:0] o_ram_wdata,
  output logic             o_ram_wen,
  output logic [aw-1:0]    o_ram_raddr,
  input  logic [width-1:0] i_ram_rdata,
  input  logic             i_dbg_req,
  input  logic             i_dbg_we,
  input  logic [5:0]       i_dbg_reg,
  input  logic [31:0]      i_dbg_wdat,
  output logic [31:0]      o_dbg_rdat,
  output logic             o_dbg_ack,
  output logic             o_dbg_err
);

  localparam int unsigned Beats    = beats(width);
  localparam int unsigned RegLimit = reg_limit(csr_regs);
  // Reads need one extra count to collect the last registered beat.
  localparam int unsigned CntW     = $clog2(Beats + 1);

  localparam logic [CntW-1:0] LastBeat = CntW'(Beats - 1);
  localparam logic [CntW-1:0] LastCap  = CntW'(Beats);

  dbg_state_e      state_q;
  logic [CntW-1:0] cnt_q;
  logic [5:0]      reg_q;
  logic [31:0]     wdat_q;
  logic [31:0]     shift_q;
  logic [31:0]     rdat_q;
  logic            ack_q;
  logic            err_q;

  logic             accept;
  logic             reg_ok;
  logic             is_x0;
  logic [aw-1:0]    base_addr;
  logic [aw-1:0]    beat_addr;
  logic [width-1:0] beat_wdata;
  logic [31:0]      rd_word;

  assign accept     = i_dbg_req & i_core_idle;
  assign reg_ok     = (32'(i_dbg_reg) < RegLimit);
  assign is_x0      = (reg_q == REG_X0);
  assign base_addr  = aw'(reg_q) * aw'(Beats);
  assign beat_addr  = base_addr + aw'(cnt_q);
  assign beat_wdata = width'(wdat_q >> (32'(cnt_q) * width));

  // Incoming beat lands in the MSBs; after all beats, beat 0 sits at the LSBs.
  if (width == 32) begin : g_rd_full
    assign rd_word = i_ram_rdata;
  end else begin : g_rd_shift
    assign rd_word = {i_ram_rdata, shift_q[31:width]};
  end

  assign o_core_rdata = i_ram_rdata;
  assign o_dbg_rdat   = rdat_q;
  assign o_dbg_ack    = ack_q;
  assign o_dbg_err    = err_q;

  // RAM port mux. Outside idle the core write port is masked entirely; the
  // debug write enable drops in the very cycle the core leaves idle.
  always_comb begin
    o_ram_waddr = i_core_waddr;
    o_ram_wdata = i_core_wdata;
    o_ram_wen   = i_core_wen;
    o_ram_raddr = i_core_raddr;
    if (state_q != StIdle) begin
      o_ram_waddr = beat_addr;
      o_ram_wdata = beat_wdata;
      o_ram_wen   = (state_q == StWr) & i_core_idle & ~is_x0;
    end
    // On the final read count the address is a don't-care; only data is taken.
    if (state_q == StRd) begin
      o_ram_raddr = beat_addr;
    end
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      reg_q   <= '0;
      wdat_q  <= '0;
      shift_q <= '0;
      rdat_q  <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (accept) begin
            reg_q  <= i_dbg_reg;
            wdat_q <= i_dbg_wdat;
            cnt_q  <= '0;
            if (!reg_ok) begin
              err_q <= 1'b1;
            end else begin
              state_q <= i_dbg_we ? StWr : StRd;
            end
          end
        end

        StWr: begin
          if (!i_core_idle) begin
            state_q <= StIdle;
            err_q   <= 1'b1;
          end else if (cnt_q == LastBeat) begin
            state_q <= StDone;
            ack_q   <= 1'b1;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end

        StRd: begin
          if (!i_core_idle) begin
            // Abort leaves rdat_q untouched; only completed reads update it.
            state_q <= StIdle;
            err_q   <= 1'b1;
          end else begin
            // Count 0 has only issued the first address; data starts at count 1.
            if (cnt_q != '0) begin
              shift_q <= rd_word;
            end
            if (cnt_q == LastCap) begin
              state_q <= StDone;
              ack_q   <= 1'b1;
              cnt_q   <= '0;
              rdat_q  <= is_x0 ? 32'd0 : rd_word;
            end else begin
              cnt_q <= cnt_q + CntW'(1);
            end
          end
        end

        StDone: begin
          state_q <= StIdle;
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serv_rf_dbg_arb.sv
module tb_serv_rf_dbg_arb;

  localparam int Width   = 2;
  localparam int CsrRegs = 4;
  localparam int N       = 32 / Width;
  localparam int Depth   = 32 * (32 + CsrRegs) / Width;
  localparam int Aw      = $clog2(Depth);
  localparam int Limit   = N + 4;

  logic             clk = 1'b0;
  logic             i_rst = 1'b1;
  logic             i_core_idle = 1'b1;
  logic [Aw-1:0]    i_core_waddr = '0;
  logic [Width-1:0] i_core_wdata = '0;
  logic             i_core_wen = 1'b0;
  logic [Aw-1:0]    i_core_raddr = '0;
  logic [Width-1:0] o_core_rdata;
  logic [Aw-1:0]    o_ram_waddr;
  logic [Width-1:0] o_ram_wdata;
  logic             o_ram_wen;
  logic [Aw-1:0]    o_ram_raddr;
  logic [Width-1:0] i_ram_rdata = '0;
  logic             i_dbg_req = 1'b0;
  logic             i_dbg_we = 1'b0;
  logic [5:0]       i_dbg_reg = '0;
  logic [31:0]      i_dbg_wdat = '0;
  logic [31:0]      o_dbg_rdat;
  logic             o_dbg_ack;
  logic             o_dbg_err;

  serv_rf_dbg_arb #(
    .width   (Width),
    .csr_regs(CsrRegs)
  ) u_dut (
    .clk         (clk),
    .i_rst       (i_rst),
    .i_core_idle (i_core_idle),
    .i_core_waddr(i_core_waddr),
    .i_core_wdata(i_core_wdata),
    .i_core_wen  (i_core_wen),
    .i_core_raddr(i_core_raddr),
    .o_core_rdata(o_core_rdata),
    .o_ram_waddr (o_ram_waddr),
    .o_ram_wdata (o_ram_wdata),
    .o_ram_wen   (o_ram_wen),
    .o_ram_raddr (o_ram_raddr),
    .i_ram_rdata (i_ram_rdata),
    .i_dbg_req   (i_dbg_req),
    .i_dbg_we    (i_dbg_we),
    .i_dbg_reg   (i_dbg_reg),
    .i_dbg_wdat  (i_dbg_wdat),
    .o_dbg_rdat  (o_dbg_rdat),
    .o_dbg_ack   (o_dbg_ack),
    .o_dbg_err   (o_dbg_err)
  );

  always #5 clk = ~clk;

  // Behavioural RAM with a registered read port.
  logic [Width-1:0] mem [Depth];
  always @(posedge clk) begin
    if (o_ram_wen) mem[o_ram_waddr] <= o_ram_wdata;
    i_ram_rdata <= mem[o_ram_raddr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  typedef struct {
    int            cyc;
    logic [Aw-1:0] addr;
    logic [1:0]    data;
  } wr_t;

  typedef struct {
    int          cyc;
    logic        err;
    logic        chk_rdat;
    logic [31:0] rdat;
  } done_t;

  wr_t   wr_q[$];
  done_t done_q[$];

  logic [31:0] regs [36];

  // Monitor: every RAM write and every ack/err is matched against the scoreboard.
  always @(negedge clk) begin
    wr_t   w;
    done_t d;
    if (o_ram_wen) begin
      if (wr_q.size() == 0) chk_eq("spurious_wen", 64'(o_ram_wen), 64'd0);
      else begin
        w = wr_q.pop_front();
        chk_eq("wen_cycle", 64'(cyc), 64'(w.cyc));
        chk_eq("wen_addr", 64'(o_ram_waddr), 64'(w.addr));
        chk_eq("wen_data", 64'(o_ram_wdata), 64'(w.data));
      end
    end
    if (o_dbg_ack || o_dbg_err) begin
      if (done_q.size() == 0) chk_eq("spurious_done", 64'({o_dbg_ack, o_dbg_err}), 64'd0);
      else begin
        d = done_q.pop_front();
        chk_eq("done_cycle", 64'(cyc), 64'(d.cyc));
        chk_eq("done_err", 64'(o_dbg_err), 64'(d.err));
        chk_eq("done_ack", 64'(o_dbg_ack), 64'(!d.err));
        if (d.chk_rdat) chk_eq("rdat", 64'(o_dbg_rdat), 64'(d.rdat));
      end
    end
  end

  localparam logic [Aw-1:0] CoreAddr = 10'd3;
  localparam logic [1:0]    CoreData = 2'b10;
  localparam logic [Aw-1:0] AbtAddr  = 10'd9;
  localparam logic [1:0]    AbtData  = 2'b01;

  // One debug transfer. Called at posedge+1 with the DUT idle; cycle k after
  // the accept edge is seen by the monitor as cyc == a0 + k.
  task automatic run_xfer(input logic we, input int r, input logic [31:0] d,
                          input int abort_at, input int rst_at, input logic core_wr);
    int  a0;
    bit  ok;
    int  nb;
    a0 = cyc;
    ok = (r < 32 + CsrRegs);
    if (core_wr) begin
      i_core_wen   = 1'b1;
      i_core_waddr = CoreAddr;
      i_core_wdata = CoreData;
      wr_q.push_back('{a0, CoreAddr, CoreData});
    end
    if (!ok) begin
      done_q.push_back('{a0 + 1, 1'b1, 1'b0, 32'd0});
    end else if (rst_at == 0) begin
      nb = (abort_at > 0) ? abort_at - 1 : N;
      if (we) begin
        for (int k = 0; k < nb; k++) begin
          if (r != 0) begin
            wr_q.push_back('{a0 + k + 1, Aw'(r * N + k), d[k*Width +: Width]});
            regs[r][k*Width +: Width] = d[k*Width +: Width];
          end
        end
      end
      if (abort_at > 0) begin
        done_q.push_back('{a0 + abort_at + 1, 1'b1, 1'b0, 32'd0});
        wr_q.push_back('{a0 + abort_at + 1, AbtAddr, AbtData});
      end else if (we) begin
        done_q.push_back('{a0 + N + 1, 1'b0, 1'b0, 32'd0});
      end else begin
        done_q.push_back('{a0 + N + 2, 1'b0, 1'b1, (r == 0) ? 32'd0 : regs[r]});
      end
      if (core_wr) begin
        for (int c = (we ? N + 2 : N + 3); c <= Limit; c++)
          wr_q.push_back('{a0 + c, CoreAddr, CoreData});
      end
    end
    i_dbg_req  = 1'b1;
    i_dbg_we   = we;
    i_dbg_reg  = 6'(r);
    i_dbg_wdat = d;
    @(posedge clk); #1;
    i_dbg_req = 1'b0;
    for (int c = 1; c <= Limit; c++) begin
      if (c == abort_at) i_core_idle = 1'b0;
      if (abort_at > 0 && c == abort_at + 1) begin
        i_core_wen   = 1'b1;
        i_core_waddr = AbtAddr;
        i_core_wdata = AbtData;
      end
      if (abort_at > 0 && c == abort_at + 2) i_core_wen = 1'b0;
      if (c == rst_at) i_rst = 1'b1;
      if (rst_at > 0 && c == rst_at + 1) i_rst = 1'b0;
      @(negedge clk);
      if (!we && ok && abort_at == 0 && rst_at == 0 && c <= N)
        chk_eq("rd_raddr", 64'(o_ram_raddr), 64'(r * N + c - 1));
      if (c == rst_at) begin
        chk_eq("rst_ack", 64'(o_dbg_ack), 64'd0);
        chk_eq("rst_err", 64'(o_dbg_err), 64'd0);
        chk_eq("rst_rdat", 64'(o_dbg_rdat), 64'd0);
        chk_eq("rst_raddr_pass", 64'(o_ram_raddr), 64'(i_core_raddr));
      end
      @(posedge clk); #1;
    end
    i_core_wen  = 1'b0;
    i_core_idle = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < Depth; i++) mem[i] <= 2'($urandom);
    for (int i = 0; i < 36; i++) regs[i] = 32'd0;
    #1;
    chk_eq("reset_ack", 64'(o_dbg_ack), 64'd0);
    chk_eq("reset_err", 64'(o_dbg_err), 64'd0);
    chk_eq("reset_rdat", 64'(o_dbg_rdat), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    i_rst = 1'b0;
    @(posedge clk); #1;

    run_xfer(1'b1, 5, 32'hDEADBEEF, 0, 0, 1'b0);
    run_xfer(1'b0, 5, 32'h0, 0, 0, 1'b0);
    run_xfer(1'b1, 0, 32'hFFFFFFFF, 0, 0, 1'b0);
    run_xfer(1'b0, 0, 32'h0, 0, 0, 1'b0);
    run_xfer(1'b1, 36, 32'h11111111, 0, 0, 1'b0);
    run_xfer(1'b1, 35, 32'h12345678, 0, 0, 1'b0);
    run_xfer(1'b0, 35, 32'h0, 0, 0, 1'b0);
    run_xfer(1'b1, 7, 32'hA5A55A5A, 6, 0, 1'b0);
    run_xfer(1'b1, 9, 32'h0F0F1234, 0, 0, 1'b1);
    run_xfer(1'b0, 9, 32'h0, 0, 0, 1'b0);
    run_xfer(1'b0, 5, 32'h0, 0, 8, 1'b0);

    // Core ports pass straight through after reset.
    i_core_wen   = 1'b1;
    i_core_waddr = 10'd7;
    i_core_wdata = 2'b01;
    i_core_raddr = 10'd80;
    wr_q.push_back('{cyc, 10'd7, 2'b01});
    @(negedge clk);
    chk_eq("core_raddr_pass", 64'(o_ram_raddr), 64'd80);
    @(posedge clk); #1;
    i_core_wen = 1'b0;
    @(negedge clk);
    chk_eq("core_rdata_pass", 64'(o_core_rdata), 64'(regs[5][1:0]));

    repeat (3) @(posedge clk);
    #1;
    chk_eq("wr_q_drained", 64'(wr_q.size()), 64'd0);
    chk_eq("done_q_drained", 64'(done_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/serv_rf_dbg_arb.md
Name: serv_rf_dbg_arb

Overview:
- Arbiter placed between the register-file RAM interface adapter and the register-file RAM inside the RF top-level wrapper.
- Shares the single width-bit RAM port pair between the SERV core and a 32-bit debug/loader port.
- The debug port reads and writes whole GPR/CSR registers by sequencing the beats serially.
- The core has the RAM whenever no debug transfer is in progress. Debug transfers start only when the core reports idle.

Parameters:
- width, 2, RAM data width in bits; legal values 1, 2, 4, 8, 16, 32.
- csr_regs, 4, number of CSR registers stored after x31 (0 or 4).
- depth, 32*(32+csr_regs)/width, number of RAM words (derived).
- aw, $clog2(depth), RAM address width (derived).

Ports:
- clk  in  1  clock
- i_rst  in  1  asynchronous active-high reset
- i_core_idle  in  1  core is halted; debug transfers may start
- i_core_waddr  in  aw  core write address
- i_core_wdata  in  width  core write data
- i_core_wen  in  1  core write enable
- i_core_raddr  in  aw  core read address
- o_core_rdata  out  width  core read data
- o_ram_waddr  out  aw  RAM write address
- o_ram_wdata  out  width  RAM write data
- o_ram_wen  out  1  RAM write enable
- o_ram_raddr  out  aw  RAM read address
- i_ram_rdata  in  width  RAM read data; registered, 1-cycle latency
- i_dbg_req  in  1  debug transfer request
- i_dbg_we  in  1  1 = write, 0 = read
- i_dbg_reg  in  6  register index: 0–31 = x0–x31, 32+ = CSR
- i_dbg_wdat  in  32  debug write data
- o_dbg_rdat  out  32  debug read data
- o_dbg_ack  out  1  transfer complete (1-cycle pulse)
- o_dbg_err  out  1  transfer rejected or aborted (1-cycle pulse)

Behaviour:
- Reset: asynchronous. State goes to IDLE. o_dbg_ack=0, o_dbg_err=0, o_dbg_rdat=0, beat counter=0.
- Beats: N = 32/width. Address = reg*N + k, k = 0..N-1. Beat k carries bits [k*width +: width], LSB first.
- States: IDLE, WR, RD, DONE.
- IDLE:
  - RAM ports are driven combinationally by the core ports.
  - Accept when i_dbg_req & i_core_idle. i_dbg_we, i_dbg_reg and i_dbg_wdat are latched at accept.
  - If i_dbg_reg >= 32+csr_regs: pulse o_dbg_err in the next cycle, no RAM access, stay IDLE.
  - Otherwise go to WR or RD.
- WR:
  - Drives o_ram_wen=1 for beats k=0..N-1, one per cycle, in cycles 1..N after accept.
  - Writes to x0 keep o_ram_wen=0 but still take N cycles.
  - Go to DONE after beat N-1.
- RD:
  - Drives o_ram_raddr for beats 0..N-1 in cycles 1..N.
  - Data for beat k is captured at cycle k+2.
  - Reads of x0 force 0 into o_dbg_rdat.
  - Go to DONE after the last capture.
- DONE: o_dbg_ack=1 for one cycle, then IDLE.
  - Write: ack at cycle N+1 after accept.
  - Read: ack at cycle N+2 after accept.
  - o_dbg_rdat holds its value until the next read completes.
- Core masking: outside IDLE, i_core_wen is blocked (o_ram_wen comes from the debug side only). o_core_rdata = i_ram_rdata at all times.
- Abort: if i_core_idle falls during WR or RD:
  - Pulse o_dbg_err the next cycle and go to IDLE.
  - Debug o_ram_wen is dropped in the same cycle the fall is seen.
  - Beats already written stay written.
  - o_dbg_rdat keeps its previous value.
- Back-to-back: if i_dbg_req is still high in IDLE after ack, a new transfer is accepted. The host must drop req in the ack cycle to avoid a repeat.
- Simultaneous req and !i_core_idle: no accept, no err; the request stays pending.
- Reset mid-transfer: immediate return to IDLE with no ack; partial RAM writes are not undone.

Decomposition:
- Package serv_rf_dbg_pkg:
  - state encoding (IDLE, WR, RD, DONE);
  - REG_X0 constant;
  - function beats(width) = 32/width;
  - function reg_limit(csr_regs) = 32+csr_regs.
- No sub-module: a beat counter, a shift register for read assembly, and the state machine fit in one module.
- Instantiated in the RF top between the RAM interface adapter and the RAM.

Test Plan (width=2, csr_regs=4, N=16):
- Write x5=0xDEADBEEF with i_core_idle=1 → o_ram_wen high for cycles 1–16; addresses 80–95; beat 0 data=2'b11, beat 15 data=2'b11; ack at cycle 17. Read x5 back → rdat=0xDEADBEEF, ack at cycle 18.
- Write x0=0xFFFFFFFF then read x0 → no o_ram_wen during the write; both transfers ack; rdat=0x00000000.
- Request reg 36 → o_dbg_err pulse 1 cycle later; no RAM access; no ack. Request reg 35 (last CSR) → normal ack; addresses 560–575.
- Start a write of x7, drop i_core_idle at cycle 6 → o_dbg_err at cycle 7; only 5 beats written; core writes pass through from the next cycle.
- i_core_wen=1 with i_core_idle=1 during a debug write → RAM sees only debug addresses/data until ack; the core write is honoured once back in IDLE.
- Assert i_rst at cycle 8 of a read → o_dbg_ack, o_dbg_err and o_dbg_rdat are 0 immediately; state IDLE; core ports pass through after reset release.
